// File: rtl/pc_sequencer_pkg.sv
// Shared opcodes, state encoding, instruction field positions and command bundle for pc_sequencer.
// Pure definitions; no logic, no latency, no flow control.
package pc_sequencer_pkg;

    localparam logic [1:0] OP_SEQ  = 2'b00;
    localparam logic [1:0] OP_BRF  = 2'b01;
    localparam logic [1:0] OP_BRB  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 14;
    localparam int COND_BIT = 13;
    localparam int OFS_MSB  = 12;
    localparam int OFS_W    = OFS_MSB + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic inc;
        logic add;
        logic sub;
    } cmd_t;

    function automatic logic [1:0] get_op(input logic [15:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/pc_sequencer_decode.sv
// Combinational instruction decode to a one-hot pc command or halt; zero latency, no flow control.
// PC_SEQUENCER_CONDBR_EN enables zero_flag-qualified branches when the COND bit is set.
module pc_sequencer_decode
    import pc_sequencer_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] word_i,
    input  logic          zero_flag_i,
    output cmd_t          cmd_o,
    output logic          halt_o
);

    logic taken;

`ifdef PC_SEQUENCER_CONDBR_EN
    assign taken = !word_i[COND_BIT] || zero_flag_i;
`else
    logic unused_cond;
    assign taken       = 1'b1;
    assign unused_cond = zero_flag_i ^ word_i[COND_BIT];
`endif

    // Offset bits are captured by the top, not decoded here.
    logic unused_ofs;
    assign unused_ofs = ^word_i[OFS_MSB:0];

    always_comb begin
        cmd_o  = '0;
        halt_o = 1'b0;
        unique case (get_op(word_i[15:0]))
            OP_SEQ: cmd_o.inc = 1'b1;
            OP_BRF: begin
                if (taken) cmd_o.add = 1'b1;
                else       cmd_o.inc = 1'b1;
            end
            OP_BRB: begin
                if (taken) cmd_o.sub = 1'b1;
                else       cmd_o.inc = 1'b1;
            end
            default: halt_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer driving pc inc/add/sub; 2 cycles per instruction plus imem wait cycles.
// Stalls in FETCH until imem_valid (no timeout); commands are registered one-cycle pulses in EXEC.
// PC_SEQUENCER_CONDBR_EN: COND=1 branches are taken only when zero_flag is set.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          zero_flag,
    input  logic [AW-1:0] pc,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_valid,
    input  logic [DW-1:0] imem_data,
    output logic          inc,
    output logic          add,
    output logic          sub,
    output logic [AW-1:0] offset,
    output logic          busy,
    output logic          halted,
    output logic [15:0]   icount
);

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic              halt_q, halt_d;
    logic [OFS_MSB:0]  ofs_q, ofs_d;
    logic [15:0]       icount_q, icount_d;
    logic              icount_en;

    cmd_t              dec_cmd;
    logic              dec_halt;

    pc_sequencer_decode #(
        .DW (DW)
    ) u_decode (
        .word_i      (imem_data),
        .zero_flag_i (zero_flag),
        .cmd_o       (dec_cmd),
        .halt_o      (dec_halt)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = '0;
        halt_d    = 1'b0;
        ofs_d     = ofs_q;
        icount_d  = icount_q + 16'd1;
        icount_en = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                // Decode at capture so the command is a clean register output in EXEC.
                if (imem_valid) begin
                    cmd_d   = dec_cmd;
                    halt_d  = dec_halt;
                    ofs_d   = imem_data[OFS_MSB:0];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                icount_en = 1'b1;
                state_d   = halt_q ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                if (start) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            halt_q  <= 1'b0;
            ofs_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            halt_q  <= halt_d;
            ofs_q   <= ofs_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          icount_q <= '0;
        else if (icount_en) icount_q <= icount_d;
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = imem_req ? pc : '0;
    assign inc       = cmd_q.inc;
    assign add       = cmd_q.add;
    assign sub       = cmd_q.sub;
    assign offset    = {{(AW-OFS_W){1'b0}}, ofs_q};
    assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign halted    = (state_q == S_HALT);
    assign icount    = icount_q;

endmodule
